rename_register_file: RTL and testbench
=======================================

// Module: rename_register_file
// PURPOSE
//   Architectural register file plus rename-status table: the consumer end of the ROB issue and commit interfaces.
//   On issue it marks rd busy with the ROB tag. On commit it writes the value and clears busy if the tag still matches.
//   Two combinational read ports with commit bypass serve the RS at dispatch.
//   A per-tag writes-rd bit, captured at issue, makes stores/branches commit without touching any register.
// PARAMETERS
//   NREG      32  number of architectural registers (x0 hardwired to 0)
//   TAGW      4   ROB tag width (16 entries)
//   XLEN      32  data width
// PORTS
//   clk              in   1     clock, all state updates on posedge
//   rst              in   1     reset, synchronous, active-low (rst==0 resets on posedge clk)
//   rdy              in   1     global ready; 0 = freeze all state
//   new_ins_flag     in   1     ROB issued an instruction this cycle
//   new_ins          in   32    issued instruction word (opcode [6:0], rd [11:7])
//   rename           in   TAGW  ROB tag of issued instruction
//   rob_flush        in   1     misprediction flush
//   commit_flag      in   1     ROB commit broadcast valid
//   commit_rename    in   TAGW  committing tag
//   commit_dest      in   5     committing rd (garbage for store/branch)
//   commit_value     in   XLEN  committing result
//   rs1_idx,rs2_idx  in   5     read addresses from RS dispatch
//   rs1_busy,rs2_busy out 1     operand pending in ROB
//   rs1_tag,rs2_tag  out  TAGW  producing ROB tag (valid when busy)
//   rs1_val,rs2_val  out  XLEN  operand value (valid when !busy)
// BEHAVIOUR
//   State: regs[NREG]×XLEN, busy[NREG], tag[NREG]×TAGW, wr_rd[16] (per-tag), all cleared on reset.
//   Reset: all regs=0, busy=0, tag=0, wr_rd=0 -> read ports give busy=0,val=0 for every index.
//   rdy==0 and rst==1: no state change; reads remain combinational on current state.
//   Issue (new_ins_flag): wr_rd[rename] <= (opcode not in {STORE 0100011, BRANCH 1100011}).
//     If wr_rd and rd!=0: busy[rd]<=1, tag[rd]<=rename.
//   Commit (commit_flag && wr_rd[commit_rename] && commit_dest!=0): regs[commit_dest]<=commit_value.
//     busy[commit_dest]<=0 only if tag[commit_dest]==commit_rename.
//   Same cycle issue+commit, same rd: value written, issue wins -> busy=1, tag=new rename.
//   Same cycle issue+commit, same tag slot (wraparound reuse): commit uses old wr_rd, issue overwrites it.
//   Flush: all busy<=0 (tags ignored). A commit in the flush cycle is still valid and writes regs.
//     Any issue in the flush cycle is dropped.
//   x0: never busy, always reads 0, writes discarded.
//   Read port (combinational, zero latency), per port:
//     idx==0 -> busy=0, val=0.
//     Else if commit this cycle hits idx with tag[idx]==commit_rename and wr_rd -> busy=0, val=commit_value (bypass).
//     Else -> busy[idx], tag[idx], regs[idx].
//     Issue in the same cycle is NOT visible on reads (RS reads the pre-issue state).
// TESTING
//   Reset low 2 cycles, then read rs1_idx=5 -> busy=0,val=0; read x0 -> 0.
//   Issue ADDI rd=3 tag=2, next cycle read x3 -> busy=1,tag=2; commit tag2 dest3 val=0x55 -> same-cycle bypass val=0x55; next cycle busy=0, reg=0x55.
//   Issue x3 tag=2, then x3 tag=7; commit tag2 val=1 -> reg x3=1, busy stays 1, tag=7; commit tag7 val=9 -> busy=0, x3=9.
//   Issue SW tag=4 (rd field=6) then commit tag4 dest=6 val=0xDEAD -> x6 unchanged and not busy.
//   Issue x8 tag=1 and x9 tag=3; assert rob_flush with commit tag1 val=0x11 -> x8=0x11, busy[8]=busy[9]=0.
//   Issue x10 tag=5 with rdy=0 -> no change; rst low mid-run with busy regs -> all busy=0, regs=0.

Source files
------------

// File: rtl/rename_register_file.sv
// rename_register_file
//   Architectural register file plus rename-status table. It sits at the
//   consumer end of the ROB issue and commit interfaces and serves two
//   combinational operand read ports to the reservation stations.
//
//   Ports
//     clk, rst           clock; synchronous active-low reset
//     rdy                global ready, 0 freezes all state
//     new_ins_flag       ROB issued an instruction (new_ins, tag rename)
//     rob_flush          misprediction flush: clears every busy bit
//     commit_*           ROB commit broadcast (tag, rd, value)
//     rs1_*/rs2_*        read ports: idx in; busy, tag, val out
module rename_register_file #(
    parameter int NREG = 32,
    parameter int TAGW = 4,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            new_ins_flag,
    input  logic [31:0]     new_ins,
    input  logic [TAGW-1:0] rename,
    input  logic            rob_flush,
    input  logic            commit_flag,
    input  logic [TAGW-1:0] commit_rename,
    input  logic [4:0]      commit_dest,
    input  logic [XLEN-1:0] commit_value,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [TAGW-1:0] rs1_tag,
    output logic [TAGW-1:0] rs2_tag,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val
);

    localparam int NTAG = 1 << TAGW;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [XLEN-1:0] r_regs  [NREG];
    logic            r_busy  [NREG];
    logic [TAGW-1:0] r_tag   [NREG];
    logic            r_wr_rd [NTAG];

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic       w_issue_wr;
    logic       w_commit_hit;
    logic       w_commit_en;
    logic       w_unused_bits;

    assign w_opcode      = new_ins[6:0];
    assign w_rd          = new_ins[11:7];
    assign w_unused_bits = ^new_ins[31:12];

    // Stores and branches occupy a ROB tag but never produce a register value.
    assign w_issue_wr   = (w_opcode != OP_STORE) && (w_opcode != OP_BRANCH);

    // A commit is only meaningful when the tag was captured as a writer.
    // The bypass is gated by rdy because a frozen cycle performs no commit.
    assign w_commit_hit = rdy && commit_flag && r_wr_rd[commit_rename];
    assign w_commit_en  = w_commit_hit && (commit_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
            for (int t = 0; t < NTAG; t++) begin
                r_wr_rd[t] <= 1'b0;
            end
        end else if (rdy) begin
            // Commit first; a later issue to the same rd overrides busy/tag.
            if (w_commit_en) begin
                r_regs[commit_dest] <= commit_value;
                if (r_tag[commit_dest] == commit_rename) begin
                    r_busy[commit_dest] <= 1'b0;
                end
            end
            if (rob_flush) begin
                for (int i = 0; i < NREG; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end else if (new_ins_flag) begin
                // Commit above already read the old wr_rd of a reused slot.
                r_wr_rd[rename] <= w_issue_wr;
                if (w_issue_wr && (w_rd != 5'd0)) begin
                    r_busy[w_rd] <= 1'b1;
                    r_tag[w_rd]  <= rename;
                end
            end
        end
    end

    // Read ports: x0 is constant zero; a matching commit is forwarded so the
    // RS never captures a tag that retires in this very cycle.
    always_comb begin
        rs1_busy = 1'b0;
        rs1_tag  = '0;
        rs1_val  = '0;
        if (rs1_idx != 5'd0) begin
            rs1_tag = r_tag[rs1_idx];
            if (w_commit_hit && (commit_dest == rs1_idx) &&
                (r_tag[rs1_idx] == commit_rename)) begin
                rs1_val = commit_value;
            end else begin
                rs1_busy = r_busy[rs1_idx];
                rs1_val  = r_regs[rs1_idx];
            end
        end
    end

    always_comb begin
        rs2_busy = 1'b0;
        rs2_tag  = '0;
        rs2_val  = '0;
        if (rs2_idx != 5'd0) begin
            rs2_tag = r_tag[rs2_idx];
            if (w_commit_hit && (commit_dest == rs2_idx) &&
                (r_tag[rs2_idx] == commit_rename)) begin
                rs2_val = commit_value;
            end else begin
                rs2_busy = r_busy[rs2_idx];
                rs2_val  = r_regs[rs2_idx];
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
module tb_rename_register_file;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] SW   = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst, rdy, new_ins_flag, rob_flush, commit_flag;
    logic [31:0] new_ins, commit_value;
    logic [3:0]  rename, commit_rename;
    logic [4:0]  commit_dest, rs1_idx, rs2_idx;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_val, rs2_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rename_register_file #(.NREG(32), .TAGW(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .new_ins_flag(new_ins_flag), .new_ins(new_ins), .rename(rename),
        .rob_flush(rob_flush),
        .commit_flag(commit_flag), .commit_rename(commit_rename),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val)
    );

    typedef struct {
        bit          rstn, rdy, iss;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [3:0]  ren;
        bit          fl, cm;
        logic [3:0]  ctag;
        logic [4:0]  cdst;
        logic [31:0] cval;
        logic [4:0]  r1;
        bit          eb1;
        logic [3:0]  et1;
        logic [31:0] ev1;
        logic [4:0]  r2;
        bit          eb2;
        logic [3:0]  et2;
        logic [31:0] ev2;
    } vec_t;

    typedef struct {
        int          port;
        int          step;
        bit          b;
        logic [3:0]  t;
        logic [31:0] v;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(bit rstn, bit rdy_i, bit iss, logic [6:0] op, logic [4:0] rd,
                               logic [3:0] ren, bit fl, bit cm, logic [3:0] ctag,
                               logic [4:0] cdst, logic [31:0] cval,
                               logic [4:0] r1, bit eb1, logic [3:0] et1, logic [31:0] ev1,
                               logic [4:0] r2, bit eb2, logic [3:0] et2, logic [31:0] ev2);
        vec_t x;
        x.rstn = rstn; x.rdy = rdy_i; x.iss = iss; x.op = op; x.rd = rd; x.ren = ren;
        x.fl = fl; x.cm = cm; x.ctag = ctag; x.cdst = cdst; x.cval = cval;
        x.r1 = r1; x.eb1 = eb1; x.et1 = et1; x.ev1 = ev1;
        x.r2 = r2; x.eb2 = eb2; x.et2 = et2; x.ev2 = ev2;
        return x;
    endfunction

    // Idle cycle that only reads.
    function automatic vec_t rd2(logic [4:0] r1, bit eb1, logic [3:0] et1, logic [31:0] ev1,
                                 logic [4:0] r2, bit eb2, logic [3:0] et2, logic [31:0] ev2);
        return v(1, 1, 0, ADDI, 0, 0, 0, 0, 0, 0, 0, r1, eb1, et1, ev1, r2, eb2, et2, ev2);
    endfunction

    task automatic check_port(input exp_t e, input logic b, input logic [3:0] t,
                              input logic [31:0] val);
        total++;
        if (b !== e.b) begin
            bad++;
            $display("FAIL step%0d rs%0d_busy: got %0b want %0b", e.step, e.port, b, e.b);
        end else if (e.b && (t !== e.t)) begin
            bad++;
            $display("FAIL step%0d rs%0d_tag: got %0d want %0d", e.step, e.port, t, e.t);
        end else if (!e.b && (val !== e.v)) begin
            bad++;
            $display("FAIL step%0d rs%0d_val: got %h want %h", e.step, e.port, val, e.v);
        end
    endtask

    // Drive one cycle between edges, push expectations, then compare the
    // combinational read ports before the next rising edge.
    task automatic apply(input vec_t x, input int step);
        exp_t e;
        @(negedge clk);
        rst           = x.rstn;
        rdy           = x.rdy;
        new_ins_flag  = x.iss;
        new_ins       = {20'd0, x.rd, x.op};
        rename        = x.ren;
        rob_flush     = x.fl;
        commit_flag   = x.cm;
        commit_rename = x.ctag;
        commit_dest   = x.cdst;
        commit_value  = x.cval;
        rs1_idx       = x.r1;
        rs2_idx       = x.r2;
        e.step = step; e.port = 1; e.b = x.eb1; e.t = x.et1; e.v = x.ev1;
        sb.push_back(e);
        e.port = 2; e.b = x.eb2; e.t = x.et2; e.v = x.ev2;
        sb.push_back(e);
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == 1) check_port(e, rs1_busy, rs1_tag, rs1_val);
            else             check_port(e, rs2_busy, rs2_tag, rs2_val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] k;
        logic [31:0] prev;
        k = 32'h01010101;
        rst = 1'b0; rdy = 1'b1; new_ins_flag = 1'b0; new_ins = '0; rename = '0;
        rob_flush = 1'b0; commit_flag = 1'b0; commit_rename = '0; commit_dest = '0;
        commit_value = '0; rs1_idx = '0; rs2_idx = '0;

        // reset and first read
        tbl.push_back(v(0,1,0,ADDI,0,0,0,0,0,0,0, 5,0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,0,ADDI,0,0,0,0,0,0,0, 5,0,0,0, 0,0,0,0));
        tbl.push_back(rd2(5,0,0,0, 0,0,0,0));
        // issue/commit with bypass
        tbl.push_back(v(1,1,1,ADDI,3,2,0,0,0,0,0, 3,0,0,0, 0,0,0,0));
        tbl.push_back(rd2(3,1,2,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,2,3,32'h55, 3,0,0,32'h55, 4,0,0,0));
        tbl.push_back(rd2(3,0,0,32'h55, 0,0,0,0));
        // stale commit keeps younger rename
        tbl.push_back(v(1,1,1,ADDI,3,2,0,0,0,0,0, 3,0,0,32'h55, 0,0,0,0));
        tbl.push_back(v(1,1,1,ADDI,3,7,0,0,0,0,0, 3,1,2,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,2,3,32'h1, 3,1,7,0, 0,0,0,0));
        tbl.push_back(rd2(3,1,7,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,7,3,32'h9, 3,0,0,32'h9, 0,0,0,0));
        tbl.push_back(rd2(3,0,0,32'h9, 0,0,0,0));
        // store commits without writing
        tbl.push_back(v(1,1,1,SW,6,4,0,0,0,0,0, 6,0,0,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,4,6,32'hDEAD, 6,0,0,0, 0,0,0,0));
        tbl.push_back(rd2(6,0,0,0, 0,0,0,0));
        // flush with simultaneous commit and dropped issue
        tbl.push_back(v(1,1,1,ADDI,8,1,0,0,0,0,0, 8,0,0,0, 9,0,0,0));
        tbl.push_back(v(1,1,1,ADDI,9,3,0,0,0,0,0, 8,1,1,0, 9,0,0,0));
        tbl.push_back(v(1,1,1,ADDI,10,5,1,1,1,8,32'h11, 8,0,0,32'h11, 9,1,3,0));
        tbl.push_back(rd2(8,0,0,32'h11, 9,0,0,0));
        tbl.push_back(rd2(10,0,0,0, 9,0,0,0));
        // rdy low freezes
        tbl.push_back(v(1,0,1,ADDI,10,5,0,0,0,0,0, 10,0,0,0, 0,0,0,0));
        tbl.push_back(rd2(10,0,0,0, 0,0,0,0));
        // same-cycle issue+commit on one rd
        tbl.push_back(v(1,1,1,ADDI,12,6,0,0,0,0,0, 12,0,0,0, 0,0,0,0));
        tbl.push_back(v(1,1,1,ADDI,12,8,0,1,6,12,32'h77, 12,0,0,32'h77, 0,0,0,0));
        tbl.push_back(rd2(12,1,8,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,8,12,32'h88, 12,0,0,32'h88, 0,0,0,0));
        tbl.push_back(rd2(12,0,0,32'h88, 0,0,0,0));
        // tag slot reuse: commit sees old wr_rd
        tbl.push_back(v(1,1,1,SW,13,9,0,0,0,0,0, 13,0,0,0, 0,0,0,0));
        tbl.push_back(v(1,1,1,ADDI,13,9,0,1,9,13,32'hAA, 13,0,0,0, 0,0,0,0));
        tbl.push_back(rd2(13,1,9,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,9,13,32'hBB, 13,0,0,32'hBB, 0,0,0,0));
        tbl.push_back(rd2(13,0,0,32'hBB, 0,0,0,0));
        // x0 never busy or written
        tbl.push_back(v(1,1,1,ADDI,0,10,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,ADDI,0,0,0,1,10,0,32'h99, 0,0,0,0, 1,0,0,0));
        tbl.push_back(rd2(0,0,0,0, 1,0,0,0));
        // reset mid-run
        tbl.push_back(v(1,1,1,ADDI,14,11,0,0,0,0,0, 14,0,0,0, 0,0,0,0));
        tbl.push_back(rd2(14,1,11,0, 3,0,0,32'h9));
        tbl.push_back(v(0,1,0,ADDI,0,0,0,0,0,0,0, 14,1,11,0, 12,0,0,32'h88));
        tbl.push_back(rd2(14,0,0,0, 3,0,0,0));
        tbl.push_back(rd2(12,0,0,0, 13,0,0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Hand-written sweep: rename, commit and read back every register x1..x31.
        for (int r = 1; r < 32; r++) begin
            prev = (r == 1) ? 32'd0 : k * (r - 1);
            apply(v(1,1,1,ADDI,5'(r),4'(r),0,0,0,0,0, 5'(r),0,0,0, 5'(r-1),0,0,prev), 100 + 2*r);
            apply(v(1,1,0,ADDI,0,0,0,1,4'(r),5'(r),k*r, 5'(r),0,0,k*r, 5'(r),0,0,k*r),
                  101 + 2*r);
        end
        for (int r = 1; r < 32; r++) begin
            apply(rd2(5'(r),0,0,k*r, 5'(32-r),0,0,k*(32-r)), 200 + r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
